seq_checker: RTL
================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter DEPTH, 32, maximum stored sequence length in colours (power of two).
REQ-002 SHALL have parameter TIMEOUT, 250000000, CHECK-state cycles allowed between player presses.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port append_valid  in  1  one-cycle request to append append_colour to the sequence.
REQ-006 SHALL have port append_colour  in  2  colour to append (00 B, 01 G, 10 R, 11 Y).
REQ-007 SHALL have port start  in  1  one-cycle request to begin checking player input against the stored sequence.
REQ-008 SHALL have port colour_valid  in  1  one-cycle strobe marking a player press.
REQ-009 SHALL have port colour  in  2  player colour, same encoding, from the key-to-colour converter.
REQ-010 SHALL have port seq_len  out  $clog2(DEPTH)+1  number of stored colours.
REQ-011 SHALL have port full  out  1  high when seq_len == DEPTH.
REQ-012 SHALL have port busy  out  1  high while in CHECK.
REQ-013 SHALL have ports match_pulse, round_done, fail  out  1 each  single-cycle registered event pulses.

Function
REQ-014 SHALL store the sequence in an internal DEPTH x 2-bit register array, indexed 0..seq_len-1 in append order.
REQ-015 SHALL implement FSM states IDLE and CHECK; reset state IDLE.
REQ-016 IDLE: append_valid with full=0 and start=0 SHALL write mem[seq_len] and increment seq_len at that edge.
REQ-017 append_valid SHALL be ignored when full=1, when in CHECK, or when start is high the same cycle (start wins).
REQ-018 IDLE: start with seq_len>0 SHALL enter CHECK, clear check index idx and timeout counter; start with seq_len==0 SHALL be ignored.
REQ-019 colour_valid in IDLE SHALL be ignored; start in CHECK SHALL be ignored.
REQ-020 CHECK: colour_valid with colour==mem[idx] and idx<seq_len-1 SHALL increment idx, clear timeout counter, and pulse match_pulse in the following cycle.
REQ-021 CHECK: matching colour_valid with idx==seq_len-1 SHALL pulse match_pulse and round_done together in the following cycle and return to IDLE; busy falls in that same cycle; sequence preserved.
REQ-022 CHECK: colour_valid with colour!=mem[idx] SHALL pulse fail in the following cycle, return to IDLE, and clear seq_len to 0.
REQ-023 CHECK: timeout counter SHALL increment each cycle without colour_valid; on reaching TIMEOUT-1 with no press, fail behaviour of REQ-022 applies (fail high exactly TIMEOUT cycles after the entering or last-accepted edge).
REQ-024 colour_valid on the timeout cycle SHALL take priority over the timeout.
REQ-025 Event pulses SHALL be high for exactly one cycle; match_pulse and fail never high together.
REQ-026 full SHALL be combinationally derived from seq_len; all other outputs registered.
REQ-027 Timeout counter width SHALL be $clog2(TIMEOUT)+1; no wrap within CHECK.

Reset
REQ-028 reset high SHALL immediately force state IDLE, seq_len=0, idx=0, counter=0, busy=0, full=0, match_pulse=0, round_done=0, fail=0, including mid-CHECK.
REQ-029 Memory contents need not be cleared on reset; they are unreadable while seq_len=0.

Verification
REQ-030 Reset, append 00,01,10 -> seq_len=3, full=0, busy=0.
REQ-031 From REQ-030, start, presses 00,01,10 spaced 3 cycles -> three match_pulses each one cycle after press, round_done with third, busy=0, seq_len=3.
REQ-032 From REQ-030, start, presses 00,11 -> one match_pulse, then fail one cycle after second press, seq_len=0, busy=0.
REQ-033 32 appends then 33rd plus simultaneous start+append -> full=1, seq_len=32, extras dropped; 32 correct presses -> round_done.
REQ-034 TIMEOUT=8, one colour stored, start, no press -> fail exactly 8 cycles after start edge; press on cycle 8 instead -> round_done, no fail.
REQ-035 reset pulsed during CHECK after one match -> all outputs 0 asynchronously; following start ignored (seq_len=0).

Source files
------------

// File: rtl/seq_checker.sv
// seq_checker: stores a colour sequence appended one entry at a time, then
// replays the player's presses against it. A wrong colour or a press that
// arrives too late ends the round with fail and discards the sequence. A
// complete correct round ends with round_done and keeps the sequence so it
// can be extended.
module seq_checker #(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 250000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     append_valid,
    input  logic [1:0]               append_colour,
    input  logic                     start,
    input  logic                     colour_valid,
    input  logic [1:0]               colour,
    output logic [$clog2(DEPTH):0]   seq_len,
    output logic                     full,
    output logic                     busy,
    output logic                     match_pulse,
    output logic                     round_done,
    output logic                     fail
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CHECK = 1'b1;

    logic [1:0]    mem [DEPTH];

    logic [0:0]    state_reg,   state_next;
    logic [LW-1:0] seq_len_reg, seq_len_next;
    logic [AW-1:0] idx_reg,     idx_next;
    logic [CW-1:0] cnt_reg,     cnt_next;
    logic          match_reg,   match_next;
    logic          done_reg,    done_next;
    logic          fail_reg,    fail_next;
    logic          mem_we;

    logic          full_w;
    logic          last_w;
    logic          hit_w;
    logic          timeout_w;

    assign full_w    = (seq_len_reg == LW'(DEPTH));
    // idx points at the final stored colour when it equals seq_len-1
    assign last_w    = ({1'b0, idx_reg} == (seq_len_reg - LW'(1)));
    assign hit_w     = (colour == mem[idx_reg]);
    assign timeout_w = (cnt_reg == CW'(TIMEOUT - 1));

    // Next-state decode: appends and start in IDLE, press checking and timeout in CHECK
    always_comb begin
        state_next   = state_reg;
        seq_len_next = seq_len_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        match_next   = 1'b0;
        done_next    = 1'b0;
        fail_next    = 1'b0;
        mem_we       = 1'b0;

        if (state_reg == S_IDLE) begin
            // start takes precedence over a same-cycle append
            if (start) begin
                if (seq_len_reg != '0) begin
                    state_next = S_CHECK;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            end else if (append_valid && !full_w) begin
                mem_we       = 1'b1;
                seq_len_next = seq_len_reg + LW'(1);
            end
        end else begin
            // a press on the timeout cycle is judged instead of timing out
            if (colour_valid) begin
                cnt_next = '0;
                if (hit_w) begin
                    match_next = 1'b1;
                    if (last_w) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + AW'(1);
                    end
                end else begin
                    fail_next    = 1'b1;
                    state_next   = S_IDLE;
                    seq_len_next = '0;
                    idx_next     = '0;
                end
            end else if (timeout_w) begin
                fail_next    = 1'b1;
                state_next   = S_IDLE;
                seq_len_next = '0;
                idx_next     = '0;
                cnt_next     = '0;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Control state and registered event pulses, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            seq_len_reg <= '0;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            match_reg   <= 1'b0;
            done_reg    <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            seq_len_reg <= seq_len_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            match_reg   <= match_next;
            done_reg    <= done_next;
            fail_reg    <= fail_next;
        end
    end

    // Sequence storage; contents are never read while seq_len is zero, so no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[seq_len_reg[AW-1:0]] <= append_colour;
        end
    end

    assign seq_len     = seq_len_reg;
    assign full        = full_w;
    assign busy        = (state_reg == S_CHECK);
    assign match_pulse = match_reg;
    assign round_done  = done_reg;
    assign fail        = fail_reg;

endmodule
